// File: rtl/mdio_arbiter.sv
// mdio_arbiter
//
// Round-robin scheduler that shares one MDIO management controller among
// NREQ station-management requesters. It grants one request at a time,
// builds the 32-bit management frame, pulses CTRL_START, and then waits for
// CTRL_DATA_RDY or a timeout. It returns DONE/ERR/RDATA to the granted
// requester.
//
// Ports
//   CLK, RESET      system clock, synchronous active-high reset
//   REQ             per-requester request level (sampled only in IDLE)
//   REQ_WRITE       per-requester operation, 1 = write
//   REQ_PHY/REQ_REG 5-bit PHY/register address per requester, packed [5i+4:5i]
//   REQ_WDATA       16-bit write data per requester, packed [16i+15:16i]
//   GNT             one-hot grant, high from issue through the RESP cycle
//   DONE            one-cycle completion pulse to the granted requester
//   ERR             high with DONE when the transaction timed out
//   RDATA           read data of the last completed read
//   CTRL_START      one-cycle start pulse to the controller
//   CTRL_T_DATA     frame to the controller, held from issue until next issue
//   CTRL_RD_DATA    controller read data
//   CTRL_DATA_RDY   controller completion pulse
//   CTRL_ABORT      one-cycle pulse on timeout (ORed into controller reset)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | no transaction; round-robin search over REQ, issue on a winner
// WAIT  | frame issued; count cycles until DATA_RDY or TIMEOUT_CYC
// RESP  | DONE/ERR presented for one cycle; grant released on exit

module mdio_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [5*NREQ-1:0]    REQ_PHY,
    input  logic [5*NREQ-1:0]    REQ_REG,
    input  logic [16*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic                 ERR,
    output logic [15:0]          RDATA,
    output logic                 CTRL_START,
    output logic [31:0]          CTRL_T_DATA,
    input  logic [15:0]          CTRL_RD_DATA,
    input  logic                 CTRL_DATA_RDY,
    output logic                 CTRL_ABORT
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYC);
    localparam logic [IW-1:0] LAST_RST    = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            start_q, start_d;
    logic [31:0]     tdata_q, tdata_d;
    logic            abort_q, abort_d;

    // Per-requester views of the packed request buses.
    logic            wr_a    [NREQ];
    logic [4:0]      phy_a   [NREQ];
    logic [4:0]      reg_a   [NREQ];
    logic [15:0]     wdata_a [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_a[i]    = REQ_WRITE[i];
            phy_a[i]   = REQ_PHY[5*i +: 5];
            reg_a[i]   = REQ_REG[5*i +: 5];
            wdata_a[i] = REQ_WDATA[16*i +: 16];
        end
    end

    // Round-robin search: LAST+1, LAST+2, ... modulo NREQ, first high REQ wins.
    logic            win_valid;
    logic [IW-1:0]   win_idx;
    int              cand;
    logic [IW-1:0]   cand_w;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_w    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand   = (int'(last_q) + k) % NREQ;
            cand_w = IW'(cand);
            if (!win_valid && REQ[cand_w]) begin
                win_valid = 1'b1;
                win_idx   = cand_w;
            end
        end
    end

    function automatic logic [31:0] build_frame(input logic        wr,
                                                input logic [4:0]  phy,
                                                input logic [4:0]  rg,
                                                input logic [15:0] wd);
        return {2'b01,
                wr ? 2'b01 : 2'b10,
                phy,
                rg,
                wr ? 2'b10 : 2'b00,
                wr ? wd : 16'h0000};
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        start_d = 1'b0;
        tdata_d = tdata_q;
        abort_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d          = win_idx;
                    wr_d             = wr_a[win_idx];
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    tdata_d          = build_frame(wr_a[win_idx], phy_a[win_idx],
                                                   reg_a[win_idx], wdata_a[win_idx]);
                    start_d          = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (CTRL_DATA_RDY) begin
                    done_d  = gnt_q;
                    state_d = S_RESP;
                    if (!wr_q) begin
                        rdata_d = CTRL_RD_DATA;
                    end
                end else if (cnt_q == TIMEOUT_VAL) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            last_q  <= LAST_RST;
            owner_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
            start_q <= 1'b0;
            tdata_q <= 32'h0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            tdata_q <= tdata_d;
            abort_q <= abort_d;
        end
    end

    assign GNT         = gnt_q;
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign RDATA       = rdata_q;
    assign CTRL_START  = start_q;
    assign CTRL_T_DATA = tdata_q;
    assign CTRL_ABORT  = abort_q;

endmodule

// File: doc/mdio_arbiter.md
# mdio_arbiter

Round-robin scheduler that shares one MDIO management controller among NREQ requesters. Each requester posts a read or write request: operation, PHY address, register address and write data. The arbiter grants one request at a time, builds the 32-bit management frame, and pulses the controller's start input. It then waits for the controller's completion pulse and returns read data and a done/error status to the granted requester. It sits between the station-management clients and the MDIO controller.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT_CYC, 63: maximum WAIT cycles before a transaction is aborted
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- REQ  in  NREQ  per-requester request level
- REQ_WRITE  in  NREQ  1 = write, 0 = read
- REQ_PHY  in  5*NREQ  PHY address; requester i uses bits [5i+4:5i]
- REQ_REG  in  5*NREQ  register address, same packing as REQ_PHY
- REQ_WDATA  in  16*NREQ  write data; requester i uses bits [16i+15:16i]
- GNT  out  NREQ  one-hot grant, high from issue through the RESP cycle
- DONE  out  NREQ  one-cycle completion pulse to the granted requester
- ERR  out  1  high with DONE when the transaction timed out
- RDATA  out  16  read data of the last completed read
- CTRL_START  out  1  one-cycle start pulse to the controller
- CTRL_T_DATA  out  32  frame to the controller, held stable from issue until RESP
- CTRL_RD_DATA  in  16  controller read data
- CTRL_DATA_RDY  in  1  controller completion pulse
- CTRL_ABORT  out  1  one-cycle pulse on timeout; the top level ORs it into the controller reset

## Operation
- Frame layout, bit 31 down to 0:
  - [31:30] = 01 (start)
  - [29:28] = 10 for read, 01 for write
  - [27:23] = PHY address
  - [22:18] = register address
  - [17:16] = 10 for write, 00 for read
  - [15:0] = write data, or 0 for a read
- State machine:
  - IDLE: if any REQ bit is high, select a winner w. On that edge, latch the winner's fields and set GNT[w]=1, CTRL_T_DATA=frame, CTRL_START=1. Clear the timeout counter and go to WAIT.
  - WAIT: CTRL_START=0 and the counter increments each cycle.
    - On CTRL_DATA_RDY, go to RESP with ERR=0. For a read, RDATA <= CTRL_RD_DATA; for a write, RDATA is unchanged.
    - Otherwise, when counter == TIMEOUT_CYC, go to RESP with ERR=1 and pulse CTRL_ABORT once.
    - If DATA_RDY and the timeout occur in the same cycle, DATA_RDY wins.
  - RESP: DONE[w]=1 for exactly one cycle and GNT[w] stays 1. On exit, GNT is cleared, LAST <= w, and the state returns to IDLE.
- Round-robin selection:
  - Search order is LAST+1, LAST+2, … modulo NREQ; the first REQ bit found high wins.
  - LAST resets to NREQ-1, so requester 0 has priority first.
- Request fields are sampled only at the grant edge; later changes to them are ignored.
- REQ is sampled only in IDLE.
  - Dropping REQ before grant withdraws the request.
  - Dropping REQ after grant does not cancel the transaction.
  - A requester clears REQ on the edge where it sees DONE; if REQ is still high in the IDLE cycle after RESP, a new transaction is issued.
- RESET at any time: state = IDLE with every output at its reset value, LAST = NREQ-1, counter = 0. No DONE is issued for the aborted transaction.
- Reset values: GNT=0, DONE=0, ERR=0, RDATA=16'h0000, CTRL_START=0, CTRL_T_DATA=32'h0, CTRL_ABORT=0.

## Timing
- All outputs are registered.
- With REQ high in IDLE at cycle 0, GNT and CTRL_START are high in cycle 1 and WAIT begins in cycle 2.
- With CTRL_DATA_RDY high in cycle n, RESP (DONE, ERR, updated RDATA) is in cycle n+1 and IDLE is in cycle n+2. The earliest next CTRL_START is cycle n+3, which guarantees the controller sees at least one idle cycle between frames.
- CTRL_START is never high in two consecutive cycles.
- Timeout: CTRL_ABORT and ERR appear TIMEOUT_CYC+1 cycles after the CTRL_START cycle.
- The default TIMEOUT_CYC exceeds the nominal 34-cycle frame.

## Test plan
- Read, single requester: requester 0 reads PHY 5'h01, register 5'h02. Required: CTRL_T_DATA=32'h60880000 with a one-cycle CTRL_START. The controller model returns 16'hA5A5, after which RDATA=16'hA5A5, DONE[0] pulses once, and ERR=0.
- Write: requester 2 writes PHY 5'h03, register 5'h1F, data 16'hBEEF. Required: CTRL_T_DATA=32'h51FEBEEF, then DONE[2] with RDATA unchanged.
- Contention: all 4 requesters hold REQ from reset and each drops it on its DONE. Required: grants in order 0,1,2,3. Next, requesters 1 and 3 re-request with LAST=3; required: 1 is granted first, then 3.
- Timeout: the controller model never returns DATA_RDY. Required: CTRL_ABORT and ERR+DONE occur 64 cycles after CTRL_START, and the next request proceeds normally.
- Reset mid-WAIT: assert RESET 10 cycles after CTRL_START. Required: every output is 0 on the next cycle, no DONE is issued, and requester 0 wins the next arbitration.
- Withdrawal and overlap:
  - Requester 1 raises and drops REQ while requester 0 is granted. Required: no grant is ever given to requester 1.
  - CTRL_DATA_RDY arrives in the same cycle as the timeout. Required: ERR=0.
